// File: rtl/bounded_count_arbiter.sv
`default_nettype none
// ============================================================================
// bounded_count_arbiter : round-robin access to one saturating counter,
//                         with a sticky lock that makes it clear-proof.
// Revision : 1.0
// ============================================================================
module bounded_count_arbiter #(
   parameter  int N_REQ = 4,
   parameter  int MAX   = 3,
   localparam int CW    = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] op,
   input  logic             lock_req,
   output logic [N_REQ-1:0] gnt,
   output logic [N_REQ-1:0] ack,
   output logic             err,
   output logic [CW-1:0]    count,
   output logic             sat,
   output logic             locked
);

   localparam int          c_pw  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CW-1:0] c_max = CW'(MAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_rst_meta;
   logic                r_rst_n;
   logic [N_REQ-1:0]    r_gnt;
   logic [N_REQ-1:0]    r_ack;
   logic                r_err;
   logic [CW-1:0]       r_count;
   logic                r_locked;
   logic                r_op;
   logic [c_pw-1:0]     r_widx;
   logic [c_pw-1:0]     r_rr_ptr;

   logic                w_found;
   logic [c_pw-1:0]     w_win;
   logic [N_REQ-1:0]    w_win_oh;

   function automatic logic [c_pw-1:0] wrap_add(input logic [c_pw-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= N_REQ) s = s - N_REQ;
      return c_pw'(s);
   endfunction

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rst_meta <= 1'b0;
         r_rst_n    <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_n    <= r_rst_meta;
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!w_found && req[wrap_add(r_rr_ptr, i)]) begin
            w_found = 1'b1;
            w_win   = wrap_add(r_rr_ptr, i);
         end
      end
      w_win_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_win_oh[i] = (w_win == c_pw'(i));
      end
   end

   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_state  <= S_IDLE;
         r_gnt    <= '0;
         r_ack    <= '0;
         r_err    <= 1'b0;
         r_count  <= '0;
         r_locked <= 1'b0;
         r_op     <= 1'b0;
         r_widx   <= '0;
         r_rr_ptr <= '0;
      end else begin
         if (lock_req) r_locked <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_ack <= '0;
               r_err <= 1'b0;
               if (w_found) begin
                  r_gnt   <= w_win_oh;
                  r_widx  <= w_win;
                  r_op    <= op[w_win];
                  r_state <= S_EXEC;
               end else begin
                  r_gnt <= '0;
               end
            end
            S_EXEC: begin
               // Lock is tested on its registered value, so a same-cycle lock_req cannot block this clear.
               if (!r_op) begin
                  if (r_count < c_max) begin
                     r_count <= r_count + CW'(1);
                     r_err   <= 1'b0;
                  end else begin
                     r_err   <= 1'b1;
                  end
               end else begin
                  if (!r_locked) begin
                     r_count <= '0;
                     r_err   <= 1'b0;
                  end else begin
                     r_err   <= 1'b1;
                  end
               end
               r_ack   <= r_gnt;
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_ack    <= '0;
               r_err    <= 1'b0;
               r_gnt    <= '0;
               r_rr_ptr <= wrap_add(r_widx, 1);
               r_state  <= S_IDLE;
            end
            default: begin
               r_ack   <= '0;
               r_err   <= 1'b0;
               r_gnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt    = r_gnt;
   assign ack    = r_ack;
   assign err    = r_err;
   assign count  = r_count;
   assign sat    = (r_count == c_max);
   assign locked = r_locked;

   a_count_le_max: assert property (@(posedge clk) disable iff (!r_rst_n) r_count <= c_max);

endmodule
`default_nettype wire

// File: tb/tb_bounded_count_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bounded_count_arbiter : directed and random stimulus against a
//                            transaction-timeline reference model.
// Revision : 1.0
// ============================================================================
module tb_bounded_count_arbiter;

   localparam int N_REQ = 4;
   localparam int MAX   = 3;

   logic       clk      = 1'b0;
   logic       resetn   = 1'b0;
   logic [3:0] req      = 4'd0;
   logic [3:0] op       = 4'd0;
   logic       lock_req = 1'b0;
   logic [3:0] gnt;
   logic [3:0] ack;
   logic       err;
   logic [1:0] count;
   logic       sat;
   logic       locked;

   int n_checks = 0;
   int n_errors = 0;
   int ack_seen = 0;

   // Reference: an accepted request occupies cycles t (grant decision), t+1 (grant shown,
   // op evaluated) and t+2 (result + ack shown); the arbiter is free again at t+3.
   bit         m_busy;
   int         m_age;
   int         m_w;
   bit         m_op;
   int         m_ptr;
   logic [3:0] e_gnt;
   logic [3:0] e_ack;
   logic       e_err;
   logic       e_locked;
   int         e_count;

   bounded_count_arbiter #(.N_REQ(N_REQ), .MAX(MAX)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .req      (req),
      .op       (op),
      .lock_req (lock_req),
      .gnt      (gnt),
      .ack      (ack),
      .err      (err),
      .count    (count),
      .sat      (sat),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy   = 1'b0;
      m_age    = 0;
      m_w      = 0;
      m_op     = 1'b0;
      m_ptr    = 0;
      e_gnt    = 4'd0;
      e_ack    = 4'd0;
      e_err    = 1'b0;
      e_locked = 1'b0;
      e_count  = 0;
   endtask

   task automatic model_next();
      int         n_count;
      logic [3:0] n_gnt;
      logic [3:0] n_ack;
      logic       n_err;
      n_count = e_count;
      n_gnt   = e_gnt;
      n_ack   = 4'd0;
      n_err   = 1'b0;
      if (!m_busy) begin
         n_gnt = 4'd0;
         for (int i = 0; i < N_REQ; i++) begin
            if (!m_busy && req[(m_ptr + i) % N_REQ]) begin
               m_w    = (m_ptr + i) % N_REQ;
               m_op   = op[m_w];
               m_busy = 1'b1;
               m_age  = 0;
               n_gnt  = 4'(1 << m_w);
            end
         end
      end else if (m_age == 0) begin
         if (!m_op) begin
            if (e_count < MAX) n_count = e_count + 1;
            else               n_err   = 1'b1;
         end else begin
            if (!e_locked) n_count = 0;
            else           n_err   = 1'b1;
         end
         n_ack = 4'(1 << m_w);
         m_age = 1;
      end else begin
         n_gnt  = 4'd0;
         m_ptr  = (m_w + 1) % N_REQ;
         m_busy = 1'b0;
      end
      e_locked = e_locked | lock_req;
      e_count  = n_count;
      e_gnt    = n_gnt;
      e_ack    = n_ack;
      e_err    = n_err;
   endtask

   task automatic step();
      @(negedge clk);
      check("gnt",        32'(gnt),    32'(e_gnt));
      check("ack",        32'(ack),    32'(e_ack));
      check("err",        32'(err),    32'(e_err));
      check("count",      32'(count),  32'(e_count));
      check("locked",     32'(locked), 32'(e_locked));
      check("sat",        32'(sat),    32'(e_count == MAX));
      check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      check("ack_onehot", 32'($onehot0(ack)), 32'd1);
      check("err_no_ack", 32'(err && (ack == 4'd0)), 32'd0);
      if (ack != 4'd0) ack_seen++;
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      req      = 4'd0;
      op       = 4'd0;
      lock_req = 1'b0;
      model_reset();
      step();
      step();
      resetn = 1'b1;
      step();
      step();
      step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      do_reset();

      // Single requester incrementing through saturation.
      ack_seen = 0;
      req = 4'b0001; op = 4'b0000;
      run(12);
      req = 4'd0;
      check("t1_ack_count", 32'(ack_seen), 32'd4);
      check("t1_count",     32'(count),    32'd3);
      check("t1_sat",       32'(sat),      32'd1);

      // All requesters, round-robin from a fresh reset.
      do_reset();
      req = 4'b1111; op = 4'b0000;
      run(15);
      req = 4'd0;
      check("t2_count", 32'(count), 32'd3);

      // Clear with lock_req landing in the clear's execute cycle, then a blocked clear.
      req = 4'b0100; op = 4'b0100;
      step();
      lock_req = 1'b1;
      step();
      lock_req = 1'b0;
      req = 4'd0;
      step();
      check("t3_clear_count", 32'(count),  32'd0);
      check("t3_locked",      32'(locked), 32'd1);
      req = 4'b0001; op = 4'b0000;
      run(3);
      req = 4'b0100; op = 4'b0100;
      step();
      step();
      check("t3_blocked_err", 32'(err),   32'd1);
      check("t3_blocked_ack", 32'(ack),   32'b0100);
      req = 4'd0;
      step();
      check("t3_count_kept", 32'(count), 32'd1);

      // Reset during an execute cycle.
      req = 4'b0010; op = 4'b0000;
      step();
      resetn = 1'b0;
      #1;
      check("t4_gnt",    32'(gnt),    32'd0);
      check("t4_ack",    32'(ack),    32'd0);
      check("t4_count",  32'(count),  32'd0);
      check("t4_locked", 32'(locked), 32'd0);
      do_reset();
      req = 4'b1111; op = 4'b0000;
      step();
      check("t4_first_gnt", 32'(gnt), 32'b0001);
      run(2);
      req = 4'd0;
      step();

      // Request dropped right after grant still completes exactly once.
      req = 4'b0010; op = 4'b0000;
      step();
      req = 4'd0;
      ack_seen = 0;
      run(4);
      check("t5_single_ack", 32'(ack_seen), 32'd1);
      check("t5_count",      32'(count),    32'd2);

      // Random stress.
      for (int i = 0; i < 600; i++) begin
         req      = 4'($urandom);
         op       = 4'($urandom);
         lock_req = ($urandom_range(0, 149) == 0);
         if (i == 300) begin
            do_reset();
         end else begin
            step();
         end
      end
      lock_req = 1'b0;
      req      = 4'd0;
      run(4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
